// File: rtl/backprop_accumulator_pkg.sv
// Shared types and limits for the back-propagation datapath: FSM states,
// the signed 32-bit bp word and its saturation bounds.
package backprop_accumulator_pkg;

    typedef enum logic {
        ACC,
        DONE
    } ba_state_t;

    typedef logic signed [31:0] bp_word_t;

    localparam logic [31:0] BP_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] BP_MIN = 32'h8000_0000;

endpackage

// File: rtl/bp_saturate.sv
// Clips a wide signed sum into the signed 32-bit bp range and flags clipping.
module bp_saturate
    import backprop_accumulator_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] value,
    output logic [31:0]      bp,
    output logic             sat
);

    // The value fits in 32 bits only when bit 31 and every bit above it agree.
    logic [ACC_W-32:0] upper;
    assign upper = value[ACC_W-1:31];

    always_comb begin
        bp  = value[31:0];
        sat = 1'b0;
        if (!((&upper) || !(|upper))) begin
            sat = 1'b1;
            bp  = value[ACC_W-1] ? BP_MIN : BP_MAX;
        end
    end

endmodule

// File: rtl/backprop_accumulator.sv
// Serially sums N_TERMS signed back-propagated contributions for one upstream
// neuron and presents the saturated 32-bit result on a valid/ready port.
module backprop_accumulator
    import backprop_accumulator_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 40,
    localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
    input  logic             ba_clk,
    input  logic             ba_rst,
    input  logic [31:0]      ba_in_bpc,
    input  logic             ba_in_valid,
    output logic             ba_in_ready,
    output logic [31:0]      ba_out_bp,
    output logic             ba_out_sat,
    output logic             ba_out_valid,
    input  logic             ba_out_ready,
    output logic [CNT_W-1:0] ba_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and the sender holds its data
    // until the transfer. Input ready is high only in ACC, output valid only in
    // DONE, so DONE always costs one bubble cycle before the next term.

    ba_state_t        state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    bp_word_t         out_bp_q;
    logic             out_sat_q;

    logic [ACC_W-1:0] sum;
    logic [31:0]      sat_bp;
    logic             sat_flag;
    logic             accept;
    logic             last_term;
    logic             release_out;

    assign sum = acc_q + {{(ACC_W-32){ba_in_bpc[31]}}, ba_in_bpc};

    bp_saturate #(
        .ACC_W(ACC_W)
    ) u_sat (
        .value(sum),
        .bp   (sat_bp),
        .sat  (sat_flag)
    );

    always_comb begin
        state_d      = state_q;
        ba_in_ready  = 1'b0;
        ba_out_valid = 1'b0;
        accept       = 1'b0;
        last_term    = 1'b0;
        release_out  = 1'b0;
        case (state_q)
            ACC: begin
                ba_in_ready = 1'b1;
                accept      = ba_in_valid;
                last_term   = accept && (count_q == CNT_W'(N_TERMS - 1));
                if (last_term) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ba_out_valid = 1'b1;
                release_out  = ba_out_ready;
                if (release_out) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge ba_clk) begin
        if (ba_rst) begin
            state_q   <= ACC;
            acc_q     <= '0;
            count_q   <= '0;
            out_bp_q  <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q   <= sum;
                count_q <= count_q + CNT_W'(1);
            end
            if (last_term) begin
                out_bp_q  <= sat_bp;
                out_sat_q <= sat_flag;
            end
            // Result fields stay visible after release until the next result.
            if (release_out) begin
                acc_q   <= '0;
                count_q <= '0;
            end
        end
    end

    assign ba_out_bp  = out_bp_q;
    assign ba_out_sat = out_sat_q;
    assign ba_count   = count_q;

endmodule
